key_hit_tracker: RTL

// Sits upstream of the key sprite renderers and the note synthesizer.

---
 rtl/key_hit_tracker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/key_hit_tracker.sv
// Maps fingertip blobs to white-key hits, debounces each key over whole frames,
// drives the pressed mask and serialises note_on/note_off events to the synth.
module key_hit_tracker #(
  parameter int NUM_KEYS        = 8,
  parameter int KEY_X0          = 0,
  parameter int KEY_Y0          = 0,
  parameter int WHITE_KEY_WIDTH = 90,
  parameter int KEY_HEIGHT      = 256,
  parameter int PRESS_FRAMES    = 3,
  parameter int RELEASE_FRAMES  = 3
) (
  input  logic                vclock,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                blob_valid,
  input  logic [10:0]         blob_x,
  input  logic [9:0]          blob_y,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                ev_valid,
  output logic                ev_on,
  output logic [3:0]          ev_key,
  input  logic                ev_ready
);

  typedef enum logic [1:0] {IDLE, UPDATE, SCAN} state_t;

  localparam logic [31:0] X_LO = 32'(KEY_X0);
  localparam logic [31:0] X_HI = 32'(KEY_X0 + NUM_KEYS * WHITE_KEY_WIDTH);
  localparam logic [31:0] Y_LO = 32'(KEY_Y0);
  localparam logic [31:0] Y_HI = 32'(KEY_Y0 + KEY_HEIGHT);
  localparam logic [3:0]  LAST_KEY = 4'(NUM_KEYS - 1);

  state_t              state, state_nx;
  logic [3:0]          idx, idx_nx;
  logic                frame_pending, pending_nx;
  logic [NUM_KEYS-1:0] hit_mask, chg_mask, kd_nx, blob_bits;
  logic [3:0]          hit_cnt [NUM_KEYS];
  logic [3:0]          miss_cnt[NUM_KEYS];
  logic [3:0]          hit_nx  [NUM_KEYS];
  logic [3:0]          miss_nx [NUM_KEYS];
  logic [31:0]         x_ext, y_ext;
  logic                blob_in;
  logic [3:0]          blob_key;
  logic                chg_sel, kd_sel;

  assign x_ext = {21'd0, blob_x};
  assign y_ext = {22'd0, blob_y};

  // Key index from a ladder of left-edge compares, avoiding a divider.
  always_comb begin
    blob_in  = blob_valid && (x_ext >= X_LO) && (x_ext < X_HI) &&
               (y_ext >= Y_LO) && (y_ext < Y_HI);
    blob_key = '0;
    for (int j = 1; j < NUM_KEYS; j++) begin
      if (x_ext >= 32'(KEY_X0 + j * WHITE_KEY_WIDTH)) blob_key = 4'(j);
    end
    blob_bits = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      blob_bits[k] = blob_in && (blob_key == 4'(k));
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (hit_mask[k]) begin
        hit_nx[k]  = (hit_cnt[k] == 4'd15) ? 4'd15 : hit_cnt[k] + 4'd1;
        miss_nx[k] = 4'd0;
      end else begin
        hit_nx[k]  = 4'd0;
        miss_nx[k] = (miss_cnt[k] == 4'd15) ? 4'd15 : miss_cnt[k] + 4'd1;
      end
      kd_nx[k] = key_down[k];
      if (hit_nx[k] == 4'(PRESS_FRAMES)) kd_nx[k] = 1'b1;
      else if (miss_nx[k] == 4'(RELEASE_FRAMES)) kd_nx[k] = 1'b0;
    end
  end

  always_comb begin
    chg_sel = 1'b0;
    kd_sel  = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (idx == 4'(k)) begin
        chg_sel = chg_mask[k];
        kd_sel  = key_down[k];
      end
    end
  end

  // Event handshake: ev_valid/ev_on/ev_key hold steady until a cycle where
  // ev_valid && ev_ready; that cycle is the transfer, and the scan moves on.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pending_nx = frame_pending | (frame_start && (state != IDLE));
    ev_valid   = 1'b0;
    ev_on      = 1'b0;
    ev_key     = 4'd0;
    case (state)
      IDLE: begin
        if (frame_start || frame_pending) begin
          state_nx   = UPDATE;
          pending_nx = 1'b0;
        end
      end
      UPDATE: begin
        state_nx = SCAN;
        idx_nx   = 4'd0;
      end
      SCAN: begin
        if (chg_sel) begin
          ev_valid = 1'b1;
          ev_key   = idx;
          ev_on    = kd_sel;
        end
        if (!chg_sel || ev_ready) begin
          if (idx == LAST_KEY) begin
            state_nx = IDLE;
            idx_nx   = 4'd0;
          end else begin
            idx_nx = idx + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      frame_pending <= 1'b0;
      hit_mask      <= '0;
      chg_mask      <= '0;
      key_down      <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        hit_cnt[k]  <= '0;
        miss_cnt[k] <= '0;
      end
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      frame_pending <= pending_nx;
      // A blob seen during UPDATE belongs to the frame now starting.
      if (state == UPDATE) begin
        hit_mask <= blob_bits;
        key_down <= kd_nx;
        chg_mask <= kd_nx ^ key_down;
        for (int k = 0; k < NUM_KEYS; k++) begin
          hit_cnt[k]  <= hit_nx[k];
          miss_cnt[k] <= miss_nx[k];
        end
      end else begin
        hit_mask <= hit_mask | blob_bits;
      end
    end
  end

endmodule
